// File: rtl/piso_pkg.sv
// Shared types and constants for the piso transmitter: AXI4-Lite widths,
// shifter states, register offsets and response codes.
package piso_pkg;

    localparam int AXI4_ADDR_BITS = 32;
    localparam int AXI4_DATA_BITS = 32;
    localparam int AXI4_STRB_BITS = AXI4_DATA_BITS / 8;
    localparam int AXI4_PROT_BITS = 3;
    localparam int AXI4_RESP_BITS = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    localparam logic [AXI4_RESP_BITS-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI4_RESP_BITS-1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/piso_fifo.sv
// Single-clock FIFO with push/pop/flush and full/empty/count flags; the head
// entry is read straight from the register array. Flush overrides push and pop.
module piso_fifo
    import piso_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/piso.sv
// AXI4-Lite fed parallel-in serial-out transmitter, LSB first, one bit per en cycle.
// Optional `PISO_IRQ_EN adds the irq port and the CTRL irq_en bit.
module piso
    import piso_pkg::*;
#(
    parameter int                        PISO_WIDTH     = 32,
    parameter int                        PISO_DEPTH     = 8,
    parameter logic [AXI4_ADDR_BITS-1:0] MMIO_BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    output logic                      sout,
    output logic                      sout_valid,
    input  logic                      s_axi4lite_aw_valid,
    output logic                      s_axi4lite_aw_ready,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,
    input  logic                      s_axi4lite_w_valid,
    output logic                      s_axi4lite_w_ready,
    input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
    input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,
    output logic                      s_axi4lite_b_valid,
    input  logic                      s_axi4lite_b_ready,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,
    input  logic                      s_axi4lite_ar_valid,
    output logic                      s_axi4lite_ar_ready,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,
    output logic                      s_axi4lite_r_valid,
    input  logic                      s_axi4lite_r_ready,
    output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
`ifdef PISO_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int CNT_W = $clog2(PISO_DEPTH) + 1;
    localparam int BIT_W = (PISO_WIDTH > 1) ? $clog2(PISO_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PISO_WIDTH - 1);

    // AXI holding registers and responses
    logic                      r_aw_held;
    logic [AXI4_ADDR_BITS-1:0] r_aw_addr;
    logic                      r_w_held;
    logic [AXI4_DATA_BITS-1:0] r_w_data;
    logic                      r_b_valid;
    logic [AXI4_RESP_BITS-1:0] r_b_resp;
    logic                      r_rd_req;
    logic [AXI4_ADDR_BITS-1:0] r_rd_addr;
    logic                      r_r_valid;
    logic [AXI4_DATA_BITS-1:0] r_r_data;

    // Shifter
    state_t                    r_state, w_state_nxt;
    logic [PISO_WIDTH-1:0]     r_shreg, w_shreg_nxt;
    logic [BIT_W-1:0]          r_bitcnt, w_bitcnt_nxt;

    logic                      w_wr_fire;
    logic                      w_wr_in_block;
    logic                      w_wr_is_data;
    logic                      w_wr_is_ctrl;
    logic                      w_rd_is_status;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_flush;
    logic [PISO_WIDTH-1:0]     w_fifo_head;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [CNT_W-1:0]          w_fifo_count;
    logic [AXI4_DATA_BITS-1:0] w_status;
    logic                      w_unused;

    assign s_axi4lite_aw_ready = !r_aw_held && !r_b_valid;
    assign s_axi4lite_w_ready  = !r_w_held && !r_b_valid;
    assign s_axi4lite_b_valid  = r_b_valid;
    assign s_axi4lite_b_resp   = r_b_resp;
    assign s_axi4lite_ar_ready = !r_rd_req && !r_r_valid;
    assign s_axi4lite_r_valid  = r_r_valid;
    assign s_axi4lite_r_data   = r_r_data;
    assign s_axi4lite_r_resp   = RESP_OKAY;

    assign w_wr_fire      = r_aw_held && r_w_held;
    assign w_wr_in_block  = (r_aw_addr[AXI4_ADDR_BITS-1:4] == MMIO_BASE_ADDR[AXI4_ADDR_BITS-1:4]);
    assign w_wr_is_data   = w_wr_in_block && (r_aw_addr[3:0] == REG_DATA);
    assign w_wr_is_ctrl   = w_wr_in_block && (r_aw_addr[3:0] == REG_CTRL);
    assign w_rd_is_status = (r_rd_addr[AXI4_ADDR_BITS-1:4] == MMIO_BASE_ADDR[AXI4_ADDR_BITS-1:4])
                          && (r_rd_addr[3:0] == REG_STATUS);

    assign w_push  = w_wr_fire && w_wr_is_data;
    assign w_flush = w_wr_fire && w_wr_is_ctrl && r_w_data[0];

    assign w_unused = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, s_axi4lite_w_strb, r_w_data};

    piso_fifo #(
        .WIDTH (PISO_WIDTH),
        .DEPTH (PISO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (r_w_data[PISO_WIDTH-1:0]),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_status             = '0;
        w_status[0]          = !w_fifo_empty;
        w_status[1]          = w_fifo_full;
        w_status[2]          = (r_state == SHIFT);
        w_status[8 +: CNT_W] = w_fifo_count;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= RESP_OKAY;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
        end else begin
            if (s_axi4lite_aw_valid && s_axi4lite_aw_ready) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi4lite_aw_addr;
            end
            if (s_axi4lite_w_valid && s_axi4lite_w_ready) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi4lite_w_data;
            end
            // Full is judged on the pre-edge count, so a push racing a pop still fails.
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_b_valid <= 1'b1;
                r_b_resp  <= (w_wr_is_data && w_fifo_full) ? RESP_SLVERR : RESP_OKAY;
            end else if (r_b_valid && s_axi4lite_b_ready) begin
                r_b_valid <= 1'b0;
            end

            if (s_axi4lite_ar_valid && s_axi4lite_ar_ready) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= s_axi4lite_ar_addr;
            end
            if (r_rd_req) begin
                r_rd_req  <= 1'b0;
                r_r_valid <= 1'b1;
                r_r_data  <= w_rd_is_status ? w_status : '0;
            end else if (r_r_valid && s_axi4lite_r_ready) begin
                r_r_valid <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_pop        = 1'b0;
        if (w_flush) begin
            w_state_nxt  = IDLE;
            w_shreg_nxt  = '0;
            w_bitcnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shreg_nxt  = w_fifo_head;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        w_shreg_nxt  = r_shreg >> 1;
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                        if (r_bitcnt == LAST_BIT) begin
                            w_bitcnt_nxt = '0;
                            if (!w_fifo_empty) begin
                                w_pop       = 1'b1;
                                w_shreg_nxt = w_fifo_head;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    assign sout       = r_shreg[0];
    assign sout_valid = (r_state == SHIFT);

`ifdef PISO_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_fire && w_wr_is_ctrl) r_irq_en <= r_w_data[1];
            r_irq <= r_irq_en && w_fifo_empty && (r_state == IDLE);
        end
    end

    assign irq = r_irq;
`endif

endmodule
